// File: rtl/spi_master_shifter_if.sv
// Bundle between the SPI shifter and its surroundings: TX/RX FIFO handshake,
// SPI pins, and status/control.
interface spi_master_shifter_if;
  logic       en;
  logic       tx_empty;
  logic       tx_rd;
  logic [7:0] tx_dout;
  logic       rx_full;
  logic       rx_wr;
  logic [7:0] rx_din;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       ncs;
  logic       busy;
  logic       rx_ovf;
  logic       ovf_clr;

  modport master (
    input  en, tx_empty, tx_dout, rx_full, miso, ovf_clr,
    output tx_rd, rx_wr, rx_din, sclk, mosi, ncs, busy, rx_ovf
  );

  modport slave (
    output en, tx_empty, tx_dout, rx_full, miso, ovf_clr,
    input  tx_rd, rx_wr, rx_din, sclk, mosi, ncs, busy, rx_ovf
  );
endinterface

// File: rtl/spi_master_shifter.sv
// SPI mode-0 master byte engine: pops TX FIFO, shifts MSB-first, pushes RX FIFO.
// Optional macro SPI_LOOPBACK_EN samples the internal MOSI register instead of the MISO pin.
module spi_master_shifter #(
  parameter int CLK_DIV = 4,
  parameter int CS_HOLD = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_master_shifter_if.master  bus
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HW = (CS_HOLD > 1) ? $clog2(CS_HOLD) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(CS_HOLD - 1);

  typedef enum logic [2:0] {IDLE, POP, LOAD, SHIFT, DONE, HOLD} state_t;

  state_t        state;
  logic [DW-1:0] div_cnt;
  logic [3:0]    edge_cnt;
  logic [HW-1:0] hold_cnt;
  logic [7:0]    tx_sr;
  logic [7:0]    rx_sr;
  logic          sclk_q, mosi_q, ncs_q, tx_rd_q, rx_wr_q, busy_q, rx_ovf_q;
  logic [7:0]    rx_din_q;
  logic          sample;
  logic          more;

`ifdef SPI_LOOPBACK_EN
  assign sample = mosi_q;
`else
  assign sample = bus.miso;
`endif

  assign more = bus.en && !bus.tx_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      div_cnt  <= '0;
      edge_cnt <= '0;
      hold_cnt <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      ncs_q    <= 1'b1;
      tx_rd_q  <= 1'b0;
      rx_wr_q  <= 1'b0;
      rx_din_q <= '0;
      busy_q   <= 1'b0;
      rx_ovf_q <= 1'b0;
    end else begin
      tx_rd_q <= 1'b0;
      rx_wr_q <= 1'b0;
      // An overflow set later in this block overrides the clear.
      if (bus.ovf_clr) rx_ovf_q <= 1'b0;
      case (state)
        IDLE: begin
          mosi_q <= 1'b0;
          if (more) begin
            state   <= POP;
            tx_rd_q <= 1'b1;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        POP: begin
          // Select drops on the way into LOAD so NCS is low for the LOAD cycle itself.
          ncs_q <= 1'b0;
          state <= LOAD;
        end
        LOAD: begin
          tx_sr    <= bus.tx_dout;
          mosi_q   <= bus.tx_dout[7];
          sclk_q   <= 1'b0;
          div_cnt  <= '0;
          edge_cnt <= '0;
          state    <= SHIFT;
        end
        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            sclk_q   <= ~sclk_q;
            edge_cnt <= edge_cnt + 4'd1;
            if (!sclk_q) begin
              rx_sr <= {rx_sr[6:0], sample};
            end else if (edge_cnt != 4'd15) begin
              tx_sr  <= {tx_sr[6:0], 1'b0};
              mosi_q <= tx_sr[6];
            end
            if (edge_cnt == 4'd15) state <= DONE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.rx_full) begin
            rx_ovf_q <= 1'b1;
          end else begin
            rx_wr_q  <= 1'b1;
            rx_din_q <= rx_sr;
          end
          if (more) begin
            state   <= POP;
            tx_rd_q <= 1'b1;
          end else begin
            state    <= HOLD;
            ncs_q    <= 1'b1;
            hold_cnt <= '0;
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) state <= IDLE;
          else                       hold_cnt <= hold_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sclk   = sclk_q;
  assign bus.mosi   = mosi_q;
  assign bus.ncs    = ncs_q;
  assign bus.tx_rd  = tx_rd_q;
  assign bus.rx_wr  = rx_wr_q;
  assign bus.rx_din = rx_din_q;
  assign bus.busy   = busy_q;
  assign bus.rx_ovf = rx_ovf_q;
endmodule

// File: tb/tb_spi_master_shifter.sv
// Randomized self-checking bench for spi_master_shifter (CLK_DIV=4 and CLK_DIV=1 instances).
module tb_spi_master_shifter;
`ifdef SPI_LOOPBACK_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_master_shifter_if s();
  spi_master_shifter_if s1();

  spi_master_shifter #(.CLK_DIV(4), .CS_HOLD(2)) dut  (.clk(clk), .rst(rst), .bus(s));
  spi_master_shifter #(.CLK_DIV(1), .CS_HOLD(1)) dut1 (.clk(clk), .rst(rst), .bus(s1));

  int total = 0;
  int bad   = 0;

  // TX FIFO model for the main instance
  logic [7:0] tx_mem [16];
  int wp = 0;
  int rp = 0;
  assign s.tx_empty = (wp == rp);
  always @(posedge clk)
    if (s.tx_rd && (wp != rp)) begin
      s.tx_dout <= tx_mem[rp % 16];
      rp <= rp + 1;
    end

  // SPI slave model: presents miso_pat MSB-first, advancing after each SCLK rise
  logic [7:0] miso_pat = 8'h00;
  int k = 0;
  always @(posedge s.sclk or posedge s.ncs or posedge rst)
    if (rst || s.ncs) k <= 0;
    else              k <= (k + 1) % 8;
  assign s.miso  = miso_pat[3'(7 - k)];
  assign s1.miso = s1.mosi;

  // Monitors
  logic [7:0] rx_log [64];
  int rx_cnt = 0;
  int txrd_cnt = 0;
  logic mosi_log [64];
  int mosi_cnt = 0;
  int rx1_cnt = 0;
  logic [7:0] rx1_last = 8'h00;
  time r1t [16];
  int r1n = 0;

  always @(negedge clk) begin
    if (s.tx_rd === 1'b1) txrd_cnt++;
    if (s.rx_wr === 1'b1) begin rx_log[rx_cnt % 64] = s.rx_din; rx_cnt++; end
    if (s1.rx_wr === 1'b1) begin rx1_last = s1.rx_din; rx1_cnt++; end
  end
  always @(posedge s.sclk)  begin mosi_log[mosi_cnt % 64] = s.mosi; mosi_cnt++; end
  always @(posedge s1.sclk) begin r1t[r1n % 16] = $time; r1n++; end

  task automatic push(input logic [7:0] b);
    tx_mem[wp % 16] = b;
    wp = wp + 1;
  endtask

  task automatic wait_ncs(input logic lvl, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (!ok && n < 3000) begin
      @(negedge clk);
      n++;
      if (s.ncs === lvl) ok = 1'b1;
    end
  endtask

  // Cycles until NCS rises (called while NCS is low)
  task automatic count_low(output int n);
    n = 0;
    while (s.ncs === 1'b0 && n < 3000) begin @(negedge clk); n++; end
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (s.busy === 1'b1 && n < 3000) begin @(negedge clk); n++; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if ({s.sclk, s.mosi, s.ncs, s.tx_rd, s.rx_wr, s.busy, s.rx_ovf} !== 7'b0010000)
      begin bad++; $display("FAIL reset_ctrl got=%b want=0010000", {s.sclk, s.mosi, s.ncs, s.tx_rd, s.rx_wr, s.busy, s.rx_ovf}); end
    total++; if (s.rx_din !== 8'h00) begin bad++; $display("FAIL reset_rx_din got=%h want=00", s.rx_din); end
    total++; if ({s1.sclk, s1.ncs, s1.busy, s1.rx_wr} !== 4'b0100)
      begin bad++; $display("FAIL reset_div1 got=%b want=0100", {s1.sclk, s1.ncs, s1.busy, s1.rx_wr}); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++; if ({s.busy, s.ncs} !== 2'b01) begin bad++; $display("FAIL idle_empty got=%b want=01", {s.busy, s.ncs}); end
  endtask

  task automatic test_single();
    logic [7:0] b, pat, exp, got;
    int m0, r0, t0, n;
    bit ok;
    b = 8'hA5; pat = 8'($urandom); miso_pat = pat;
    exp = LB ? b : pat;
    m0 = mosi_cnt; r0 = rx_cnt; t0 = txrd_cnt;
    push(b);
    wait_ncs(1'b0, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_start got=timeout want=ncs_low"); end
    count_low(n);
    total++; if (n !== 66) begin bad++; $display("FAIL single_ncs_low got=%0d want=66", n); end
    count_busy(n);
    total++; if (n !== 3) begin bad++; $display("FAIL single_busy_tail got=%0d want=3", n); end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) got[7-i] = mosi_log[(m0 + i) % 64];
    total++; if (got !== b || mosi_cnt - m0 !== 8) begin bad++; $display("FAIL single_mosi got=%h/%0d want=%h/8", got, mosi_cnt - m0, b); end
    total++; if (rx_cnt - r0 !== 1 || rx_log[r0 % 64] !== exp) begin bad++; $display("FAIL single_rx got=%0d/%h want=1/%h", rx_cnt - r0, rx_log[r0 % 64], exp); end
    total++; if (txrd_cnt - t0 !== 1) begin bad++; $display("FAIL single_txrd got=%0d want=1", txrd_cnt - t0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bs [3];
    int r0, t0, n;
    bit ok;
    bs[0] = 8'h01; bs[1] = 8'h80; bs[2] = 8'hFF;
    miso_pat = 8'h3C;
    r0 = rx_cnt; t0 = txrd_cnt;
    for (int i = 0; i < 3; i++) push(bs[i]);
    wait_ncs(1'b0, ok);
    total++; if (!ok) begin bad++; $display("FAIL burst_start got=timeout want=ncs_low"); end
    count_low(n);
    total++; if (n !== 200) begin bad++; $display("FAIL burst_ncs_low got=%0d want=200", n); end
    count_busy(n);
    repeat (2) @(negedge clk);
    total++; if (rx_cnt - r0 !== 3) begin bad++; $display("FAIL burst_rx_count got=%0d want=3", rx_cnt - r0); end
    for (int i = 0; i < 3; i++) begin
      total++; if (rx_log[(r0 + i) % 64] !== (LB ? bs[i] : 8'h3C))
        begin bad++; $display("FAIL burst_rx%0d got=%h want=%h", i, rx_log[(r0 + i) % 64], LB ? bs[i] : 8'h3C); end
    end
    total++; if (txrd_cnt - t0 !== 3) begin bad++; $display("FAIL burst_txrd got=%0d want=3", txrd_cnt - t0); end
  endtask

  task automatic test_overflow();
    int r0, n;
    bit ok;
    r0 = rx_cnt;
    s.rx_full = 1'b1;
    push(8'h5A);
    wait_ncs(1'b0, ok);
    count_low(n);
    total++; if (s.rx_ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", s.rx_ovf); end
    count_busy(n);
    repeat (20) @(negedge clk);
    total++; if (s.rx_ovf !== 1'b1 || rx_cnt !== r0) begin bad++; $display("FAIL ovf_sticky got=%b/%0d want=1/0", s.rx_ovf, rx_cnt - r0); end
    s.ovf_clr = 1'b1; @(negedge clk); s.ovf_clr = 1'b0;
    total++; if (s.rx_ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", s.rx_ovf); end
    push(8'h96);
    wait_ncs(1'b0, ok);
    repeat (65) @(negedge clk);
    s.ovf_clr = 1'b1; @(negedge clk); s.ovf_clr = 1'b0;
    total++; if ({s.rx_ovf, s.ncs} !== 2'b11) begin bad++; $display("FAIL ovf_set_wins got=%b want=11", {s.rx_ovf, s.ncs}); end
    count_busy(n);
    s.ovf_clr = 1'b1; @(negedge clk); s.ovf_clr = 1'b0; s.rx_full = 1'b0;
    @(negedge clk);
    total++; if (s.rx_ovf !== 1'b0 || rx_cnt !== r0) begin bad++; $display("FAIL ovf_final got=%b/%0d want=0/0", s.rx_ovf, rx_cnt - r0); end
  endtask

  task automatic test_en_drop();
    logic [7:0] b0, b1, pat;
    int r0, t0, n;
    bit ok;
    b0 = 8'($urandom); b1 = 8'($urandom); pat = 8'($urandom); miso_pat = pat;
    r0 = rx_cnt; t0 = txrd_cnt;
    push(b0); push(b1);
    wait_ncs(1'b0, ok);
    repeat (30) @(negedge clk);
    s.en = 1'b0;
    count_low(n);
    total++; if (n !== 36) begin bad++; $display("FAIL endrop_ncs_low got=%0d want=36", n); end
    count_busy(n);
    repeat (10) @(negedge clk);
    total++; if (rx_cnt - r0 !== 1 || rx_log[r0 % 64] !== (LB ? b0 : pat))
      begin bad++; $display("FAIL endrop_rx0 got=%0d/%h want=1/%h", rx_cnt - r0, rx_log[r0 % 64], LB ? b0 : pat); end
    total++; if (txrd_cnt - t0 !== 1 || {s.busy, s.ncs} !== 2'b01)
      begin bad++; $display("FAIL endrop_stop got=%0d/%b want=1/01", txrd_cnt - t0, {s.busy, s.ncs}); end
    s.en = 1'b1;
    wait_ncs(1'b0, ok);
    total++; if (!ok) begin bad++; $display("FAIL endrop_resume got=timeout want=ncs_low"); end
    count_low(n);
    count_busy(n);
    repeat (2) @(negedge clk);
    total++; if (rx_cnt - r0 !== 2 || rx_log[(r0 + 1) % 64] !== (LB ? b1 : pat))
      begin bad++; $display("FAIL endrop_rx1 got=%0d/%h want=2/%h", rx_cnt - r0, rx_log[(r0 + 1) % 64], LB ? b1 : pat); end
    total++; if (txrd_cnt - t0 !== 2) begin bad++; $display("FAIL endrop_txrd got=%0d want=2", txrd_cnt - t0); end
  endtask

  task automatic test_reset_mid();
    int r0, edges, n;
    logic prev;
    bit ok;
    r0 = rx_cnt;
    miso_pat = 8'($urandom);
    push(8'($urandom));
    wait_ncs(1'b0, ok);
    edges = 0; n = 0; prev = s.sclk;
    while (edges < 5 && n < 1000) begin
      @(negedge clk); n++;
      if (s.sclk !== prev) begin edges++; prev = s.sclk; end
    end
    total++; if (edges !== 5 || s.sclk !== 1'b1) begin bad++; $display("FAIL rstmid_edges got=%0d/%b want=5/1", edges, s.sclk); end
    rst = 1'b1;
    #1;
    total++; if ({s.sclk, s.mosi, s.ncs, s.tx_rd, s.rx_wr, s.busy, s.rx_ovf, s.rx_din} !== {7'b0010000, 8'h00})
      begin bad++; $display("FAIL rstmid_async got=%b want=001000000000000", {s.sclk, s.mosi, s.ncs, s.tx_rd, s.rx_wr, s.busy, s.rx_ovf, s.rx_din}); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    total++; if (rx_cnt !== r0 || {s.busy, s.ncs, s.sclk} !== 3'b010)
      begin bad++; $display("FAIL rstmid_after got=%0d/%b want=0/010", rx_cnt - r0, {s.busy, s.ncs, s.sclk}); end
  endtask

  task automatic test_clk_div1();
    int r0, e0, n, badp;
    r0 = rx1_cnt; e0 = r1n;
    s1.tx_dout = 8'hC3; s1.tx_empty = 1'b0;
    n = 0;
    while (s1.tx_rd !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    s1.tx_empty = 1'b1;
    total++; if (n >= 100) begin bad++; $display("FAIL div1_pop got=timeout want=tx_rd"); end
    n = 0;
    while (s1.busy === 1'b1 && n < 500) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    badp = 0;
    for (int i = 1; i < 8; i++) if (r1t[(e0 + i) % 16] - r1t[(e0 + i - 1) % 16] != 20) badp++;
    total++; if (r1n - e0 !== 8 || badp !== 0) begin bad++; $display("FAIL div1_sclk got=%0d rises/%0d bad periods want=8/0", r1n - e0, badp); end
    total++; if (rx1_cnt - r0 !== 1 || rx1_last !== 8'hC3) begin bad++; $display("FAIL div1_rx got=%0d/%h want=1/c3", rx1_cnt - r0, rx1_last); end
  endtask

  task automatic test_random();
    logic [7:0] bs [4];
    logic [7:0] pat;
    int nb, r0, t0, n;
    bit ok;
    for (int r = 0; r < 4; r++) begin
      nb = int'($urandom_range(1, 4));
      pat = 8'($urandom); miso_pat = pat;
      r0 = rx_cnt; t0 = txrd_cnt;
      for (int i = 0; i < nb; i++) begin bs[i] = 8'($urandom); push(bs[i]); end
      wait_ncs(1'b0, ok);
      count_low(n);
      total++; if (!ok || n !== 66 * nb + (nb - 1)) begin bad++; $display("FAIL rand%0d_ncs_low got=%0d want=%0d", r, n, 66 * nb + nb - 1); end
      count_busy(n);
      repeat (2) @(negedge clk);
      total++; if (rx_cnt - r0 !== nb || txrd_cnt - t0 !== nb)
        begin bad++; $display("FAIL rand%0d_counts got=%0d/%0d want=%0d", r, rx_cnt - r0, txrd_cnt - t0, nb); end
      for (int i = 0; i < nb; i++) begin
        total++; if (rx_log[(r0 + i) % 64] !== (LB ? bs[i] : pat))
          begin bad++; $display("FAIL rand%0d_rx%0d got=%h want=%h", r, i, rx_log[(r0 + i) % 64], LB ? bs[i] : pat); end
      end
    end
  endtask

  initial begin
    s.en = 1'b1; s.rx_full = 1'b0; s.ovf_clr = 1'b0;
    s1.en = 1'b1; s1.rx_full = 1'b0; s1.ovf_clr = 1'b0;
    s1.tx_empty = 1'b1; s1.tx_dout = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_en_drop();
    test_reset_mid();
    test_clk_div1();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
